barril_motion: RTL
==================

Name: barril_motion

Overview:
- Sequential position generator for one rolling barrel.
- Sits directly upstream of the barrel sprite-position stage. It drives that stage's curr_h, curr_v and display_barril inputs.
- Walks the barrel across a fixed stack of platforms: roll right, drop, roll left, drop, and so on, until it leaves the bottom platform.
- Position advances only on the once-per-frame tick, so the draw stage never sees a mid-frame position change.

Parameters:
- H_MIN, 10'd32, left roll limit (pixel column of sprite top-left).
- H_MAX, 10'd592, right roll limit. Must satisfy H_MAX+16 <= 639.
- V_TOP, 10'd64, sprite top row on the top platform (level 0).
- LEVEL_STEP, 10'd96, vertical distance between platforms.
- NUM_LEVELS, 4, number of platforms, 1..8.
- H_STEP, 10'd2, pixels moved per roll tick.
- V_STEP, 10'd4, pixels moved per fall tick. LEVEL_STEP must be a multiple of V_STEP.
- SPAWN_H, 10'd32, spawn column, H_MIN <= SPAWN_H < H_MAX.

Ports:
- clk, in, 1, system clock (25 MHz pixel clock).
- rst_n, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse per frame (start of vblank).
- spawn, in, 1, request a new barrel; level-sampled.
- kill, in, 1, remove barrel immediately (hit or game reset).
- curr_h, out, 10, sprite top-left column.
- curr_v, out, 10, sprite top-left row.
- display_barril, out, 1, barrel visible.
- busy, out, 1, barrel in flight (state != IDLE).
- done, out, 1, one-cycle pulse when the barrel exits the bottom platform normally.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, curr_h=SPAWN_H, curr_v=V_TOP.
  - level=0, target_v=V_TOP, dir_r=1.
  - display_barril=0, done=0.
- States: IDLE, ROLL_R, ROLL_L, FALL. All registered outputs update on the rising clk edge.
- IDLE:
  - If spawn=1 and kill=0: next cycle state=ROLL_R, curr_h=SPAWN_H, curr_v=V_TOP, level=0, display_barril=1.
  - Spawn latency is 1 cycle. It does not wait for frame_tick.
- Movement happens only in cycles with frame_tick=1. With frame_tick=0, every register except done holds.
- ROLL_R, on each tick:
  - If curr_h+H_STEP >= H_MAX: curr_h=H_MAX (clamped), then edge handling.
  - Otherwise curr_h += H_STEP.
- ROLL_L, on each tick:
  - If curr_h <= H_MIN+H_STEP: curr_h=H_MIN (clamped), then edge handling.
  - Otherwise curr_h -= H_STEP.
  - Compute with an 11-bit compare; no underflow wrap is permitted.
- Edge handling happens in the same tick as the clamp:
  - If level==NUM_LEVELS-1: state=IDLE, display_barril=0, done=1 for exactly one cycle. curr_h and curr_v hold their last values.
  - Otherwise: state=FALL, target_v=curr_v+LEVEL_STEP, dir_r=~dir_r.
- FALL, on each tick:
  - curr_v += V_STEP.
  - When the new curr_v equals target_v: level += 1, then state=ROLL_R if dir_r=1, else ROLL_L.
  - curr_h is frozen during FALL.
- Spawn while busy=1 is ignored; there is no queueing.
- kill=1 in any state:
  - Next cycle state=IDLE, display_barril=0, done=0.
  - Has priority over spawn, frame_tick and edge handling.
  - In IDLE it is a no-op.
- Simultaneous kill and edge-exit on the same tick: kill wins and no done pulse is produced.
- busy = (state != IDLE), combinational from the state register.
- display_barril equals busy at all times.
- Arithmetic is 10-bit unsigned. Parameter constraints guarantee curr_v never exceeds V_TOP+(NUM_LEVELS-1)*LEVEL_STEP, which is <= 463 with defaults.
- Reset asserted mid-flight: immediate return to reset values; no done pulse.

Test Plan:
- Reset then spawn: rst_n low 3 cycles, release, spawn=1 one cycle -> next cycle busy=1, display_barril=1, curr_h=32, curr_v=64; with no frame_tick, values hold for 100 cycles.
- Roll right to edge: after spawn, apply 280 frame_ticks -> curr_h=592 at tick 280, state FALL, target_v=160; 24 more ticks -> curr_v=160, state ROLL_L, curr_h still 592.
- Left clamp with non-multiple step: H_STEP=3, H_MIN=32, curr_h=34 in ROLL_L, one tick -> curr_h=32, state FALL; no wrap to 1023.
- Full traversal: defaults, spawn, tick until done -> done pulses once after the level-3 left edge; final curr_v=352, curr_h=32; display_barril=0; busy=0 the following cycle.
- Kill priority: mid ROLL_R, assert kill together with spawn and frame_tick -> next cycle IDLE, display_barril=0, done=0; spawn the next cycle restarts at (32,64).
- Kill on exit tick plus async reset: kill coincident with the final edge tick -> no done pulse; rst_n low mid-FALL -> outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/barril_motion.sv
// Position generator for one rolling barrel.
// Rolls across a stack of platforms, one step per frame tick.
module barril_motion #(
   parameter logic [9:0] H_MIN      = 10'd32,
   parameter logic [9:0] H_MAX      = 10'd592,
   parameter logic [9:0] V_TOP      = 10'd64,
   parameter logic [9:0] LEVEL_STEP = 10'd96,
   parameter int         NUM_LEVELS = 4,
   parameter logic [9:0] H_STEP     = 10'd2,
   parameter logic [9:0] V_STEP     = 10'd4,
   parameter logic [9:0] SPAWN_H    = 10'd32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       spawn,
   input  logic       kill,
   output logic [9:0] curr_h,
   output logic [9:0] curr_v,
   output logic       display_barril,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROLL_R = 2'd1,
      ROLL_L = 2'd2,
      FALL   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] curr_h_q, curr_h_d;
   logic [9:0] curr_v_q, curr_v_d;
   logic [9:0] target_v_q, target_v_d;
   logic [2:0] level_q, level_d;
   logic       dir_r_q, dir_r_d;
   logic       done_q, done_d;

   logic [10:0] h_sum;
   logic [10:0] l_lim;
   logic        at_r;
   logic        at_l;
   logic        last_lvl;
   logic [9:0]  v_next;
   logic        edge_hit;

   // Next-state and datapath update for the barrel walk.
   always_comb begin
      state_d    = state_q;
      curr_h_d   = curr_h_q;
      curr_v_d   = curr_v_q;
      target_v_d = target_v_q;
      level_d    = level_q;
      dir_r_d    = dir_r_q;
      done_d     = 1'b0;
      edge_hit   = 1'b0;

      h_sum    = {1'b0, curr_h_q} + {1'b0, H_STEP};
      l_lim    = {1'b0, H_MIN} + {1'b0, H_STEP};
      at_r     = h_sum >= {1'b0, H_MAX};
      at_l     = {1'b0, curr_h_q} <= l_lim;
      last_lvl = level_q == 3'(NUM_LEVELS - 1);
      v_next   = curr_v_q + V_STEP;

      if (kill) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (spawn) begin
                  state_d    = ROLL_R;
                  curr_h_d   = SPAWN_H;
                  curr_v_d   = V_TOP;
                  target_v_d = V_TOP;
                  level_d    = 3'd0;
                  dir_r_d    = 1'b1;
               end
            end
            ROLL_R: begin
               if (frame_tick) begin
                  if (at_r) begin
                     curr_h_d = H_MAX;
                     edge_hit = 1'b1;
                  end else begin
                     curr_h_d = curr_h_q + H_STEP;
                  end
               end
            end
            ROLL_L: begin
               if (frame_tick) begin
                  if (at_l) begin
                     curr_h_d = H_MIN;
                     edge_hit = 1'b1;
                  end else begin
                     curr_h_d = curr_h_q - H_STEP;
                  end
               end
            end
            FALL: begin
               if (frame_tick) begin
                  curr_v_d = v_next;
                  if (v_next == target_v_q) begin
                     level_d = level_q + 3'd1;
                     state_d = dir_r_q ? ROLL_R : ROLL_L;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (edge_hit) begin
            if (last_lvl) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d    = FALL;
               target_v_d = curr_v_q + LEVEL_STEP;
               dir_r_d    = ~dir_r_q;
            end
         end
      end
   end

   // State and position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         curr_h_q   <= SPAWN_H;
         curr_v_q   <= V_TOP;
         target_v_q <= V_TOP;
         level_q    <= 3'd0;
         dir_r_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         curr_h_q   <= curr_h_d;
         curr_v_q   <= curr_v_d;
         target_v_q <= target_v_d;
         level_q    <= level_d;
         dir_r_q    <= dir_r_d;
         done_q     <= done_d;
      end
   end

   assign curr_h         = curr_h_q;
   assign curr_v         = curr_v_q;
   assign busy           = state_q != IDLE;
   assign display_barril = busy;
   assign done           = done_q;

endmodule
